channel_request_scheduler: RTL

// - Upstream feeder for one memory channel controller. Buffers host commands in a FIFO.
// - Issues one transaction at a time over the channel req/ack interface.
// - Returns read data and write completions to the host on a response port.
// - Sits between the host/NoC command port and the per-channel controller.

---
 rtl/mem_sched_pkg.sv | 30 +++
 rtl/sched_cmd_fifo.sv | 51 +++++
 rtl/channel_request_scheduler.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types for the channel request scheduler: FSM states, the queued
// command record and a constant clog2 helper.
package mem_sched_pkg;

  localparam int unsigned SchedAddrWidth = 32;
  localparam int unsigned SchedDataWidth = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [SchedAddrWidth-1:0] addr;
    logic [SchedDataWidth-1:0] wdata;
    logic                      wr;
  } sched_cmd_t;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sched_cmd_fifo.sv
// Synchronous FIFO of sched_cmd_t. Pointers carry one extra wrap bit so
// full/empty are distinguished without a separate counter.
module sched_cmd_fifo
  import mem_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PtrWidth = clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  sched_cmd_t          push_cmd,
  input  logic                pop,
  output sched_cmd_t          head,
  output logic                full,
  output logic                empty,
  output logic [PtrWidth-1:0] count
);

  localparam int unsigned IdxWidth = PtrWidth - 1;

  sched_cmd_t          mem_q [DEPTH];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic                do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (wr_ptr_q[PtrWidth-1] != rd_ptr_q[PtrWidth-1]) &&
                 (wr_ptr_q[IdxWidth-1:0] == rd_ptr_q[IdxWidth-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign count = wr_ptr_q - rd_ptr_q;
  assign head  = mem_q[rd_ptr_q[IdxWidth-1:0]];

  // Pointer update; both may advance in the same cycle leaving count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IdxWidth-1:0]] <= push_cmd;
  end

endmodule

// File: rtl/channel_request_scheduler.sv
// Channel request scheduler: queues host commands and issues them one at a
// time to a memory channel controller, returning completions on rsp_*.
// Optional statistics counters are enabled by defining SCHED_STATS_EN.
// ADDR_WIDTH/DATA_WIDTH must match the package command record widths.
module channel_request_scheduler
  import mem_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SchedAddrWidth,
  parameter int unsigned DATA_WIDTH = SchedDataWidth,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic                  cmd_wr,
  output logic                  ch_req,
  output logic [ADDR_WIDTH-1:0] ch_addr,
  output logic [DATA_WIDTH-1:0] ch_wdata,
  output logic                  ch_wr_en,
  input  logic                  ch_ack,
  input  logic                  ch_valid,
  input  logic [DATA_WIDTH-1:0] ch_rdata,
  output logic                  rsp_valid,
  output logic                  rsp_is_wr,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]           stat_rd_cnt,
  output logic [31:0]           stat_wr_cnt,
  output logic [15:0]           stat_to_cnt,
  output logic [15:0]           stat_max_wait
`endif
);

  localparam int unsigned CountWidth = clog2(DEPTH) + 1;
  localparam int unsigned TimerWidth = clog2(TIMEOUT);

  sched_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic [TimerWidth-1:0] timer_q, timer_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_is_wr_q, rsp_is_wr_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  timeout_hit;

  sched_cmd_t            fifo_in, fifo_head;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [CountWidth-1:0] fifo_count;

  assign fifo_in.addr  = cmd_addr;
  assign fifo_in.wdata = cmd_wdata;
  assign fifo_in.wr    = cmd_wr;

  sched_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (cmd_valid),
    .push_cmd (fifo_in),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign cmd_ready   = !fifo_full;
  assign busy        = (state_q != IDLE) || !fifo_empty;
  assign ch_addr     = addr_q;
  assign ch_wdata    = wdata_q;
  assign ch_wr_en    = wr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_is_wr   = rsp_is_wr_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign timeout_hit = (timer_q == TimerWidth'(TIMEOUT - 1));

  // Next-state, hold-register load on pop, timeout and response generation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    timer_d     = timer_q;
    rsp_valid_d = 1'b0;
    rsp_is_wr_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    fifo_pop    = 1'b0;
    ch_req      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          addr_d   = fifo_head.addr;
          wdata_d  = fifo_head.wdata;
          wr_d     = fifo_head.wr;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        ch_req  = 1'b1;
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // An ack in the final counted cycle still wins over the timeout.
        if (ch_ack) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_is_wr_d = wr_q;
          rsp_rdata_d = ch_valid ? ch_rdata : '0;
        end else if (timeout_hit) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_is_wr_d = wr_q;
          rsp_err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TimerWidth'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, hold, timer and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      timer_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_is_wr_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      timer_q     <= timer_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_is_wr_q <= rsp_is_wr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // FIFO occupancy can never exceed its depth.
  assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= CountWidth'(DEPTH));

`ifdef SCHED_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d, max_wait_q, max_wait_d;
  logic [31:0] wait_len;

  // Saturating statistics updated as each WAIT period ends.
  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    to_cnt_d   = to_cnt_q;
    max_wait_d = max_wait_q;
    wait_len   = 32'(timer_q) + 32'd1;
    if (state_q == WAIT) begin
      if (ch_ack) begin
        if (wr_q) begin
          if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 32'd1;
        end else begin
          if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 32'd1;
        end
      end else if (timeout_hit) begin
        if (to_cnt_q != '1) to_cnt_d = to_cnt_q + 16'd1;
      end
      if ((ch_ack || timeout_hit) && (wait_len > 32'(max_wait_q))) begin
        max_wait_d = (wait_len > 32'h0000_ffff) ? 16'hffff : wait_len[15:0];
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      to_cnt_q   <= '0;
      max_wait_q <= '0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      to_cnt_q   <= to_cnt_d;
      max_wait_q <= max_wait_d;
    end
  end

  assign stat_rd_cnt   = rd_cnt_q;
  assign stat_wr_cnt   = wr_cnt_q;
  assign stat_to_cnt   = to_cnt_q;
  assign stat_max_wait = max_wait_q;
`endif

endmodule
